// File: rtl/serial_frame_rx_if.sv
// Byte/handshake/error bundle of the serial frame receiver.
// master: receiver side (drives byte, VALID and error pulses).
// slave:  consumer side (drives READY).
interface serial_frame_rx_if;
  logic [7:0] DATA_OUT;
  logic       VALID;
  logic       READY;
  logic       PAR_ERR;
  logic       FRM_ERR;
  logic       OVERRUN;

  modport master (
    output DATA_OUT,
    output VALID,
    output PAR_ERR,
    output FRM_ERR,
    output OVERRUN,
    input  READY
  );

  modport slave (
    input  DATA_OUT,
    input  VALID,
    input  PAR_ERR,
    input  FRM_ERR,
    input  OVERRUN,
    output READY
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver.
// Line format: start(0), D7..D0 MSB first, even parity, stop(1).
// One line bit is sampled per CLOCK edge with ENABLE=1.
// The received byte is offered on a VALID/READY handshake.
// Parity, framing and overrun errors are one-cycle pulses.
module serial_frame_rx (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              S_IN,
  serial_frame_rx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;

  logic [7:0] data_q;
  logic       valid_q;
  logic       par_err_q;
  logic       frm_err_q;
  logic       overrun_q;

  // Parity of D7..D0 plus the parity bit must be even.
  logic       parity_ok;
  assign parity_ok = ~(^shift ^ par_bit);

  // Frame FSM, output buffer and handshake.
  // Error pulses clear on every clock, so they stay one cycle wide
  // even while ENABLE is low. A delivery in the stop-bit cycle takes
  // priority over the handshake clear of VALID.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;

      if (valid_q && bus.READY) begin
        valid_q <= 1'b0;
      end

      if (ENABLE) begin
        case (state)
          IDLE: begin
            if (!S_IN) begin
              state   <= DATA;
              bit_cnt <= '0;
              shift   <= '0;
            end
          end

          DATA: begin
            shift   <= {shift[6:0], S_IN};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end

          PARITY: begin
            par_bit <= S_IN;
            state   <= STOP;
          end

          STOP: begin
            if (S_IN) begin
              state <= IDLE;
              if (parity_ok) begin
                if (!valid_q || bus.READY) begin
                  data_q  <= shift;
                  valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                par_err_q <= 1'b1;
              end
            end else begin
              frm_err_q <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end

          WAIT_HIGH: begin
            if (S_IN) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.DATA_OUT = data_q;
  assign bus.VALID    = valid_q;
  assign bus.PAR_ERR  = par_err_q;
  assign bus.FRM_ERR  = frm_err_q;
  assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx: frame table, directed corner
// sequences and randomized traffic against a frame-level model.
module tb_serial_frame_rx;

  logic CLOCK;
  logic RESET;
  logic ENABLE;
  logic S_IN;

  serial_frame_rx_if rx_bus ();

  serial_frame_rx dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .S_IN   (S_IN),
    .bus    (rx_bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int total;
  int bad;

  // Reference model: collects enabled line samples after a start bit
  // and judges the frame once ten of them are in hand.
  logic       mq[$];
  bit         m_busy;
  bit         m_wait;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_par;
  bit         m_frm;
  bit         m_ovr;

  task automatic model_edge(input bit rst, input bit en, input bit s, input bit rdy);
    bit         have;
    logic [7:0] b;
    int         ones;
    if (rst) begin
      mq.delete();
      m_busy  = 0;
      m_wait  = 0;
      m_data  = 8'h00;
      m_valid = 0;
      m_par   = 0;
      m_frm   = 0;
      m_ovr   = 0;
      return;
    end
    m_par = 0;
    m_frm = 0;
    m_ovr = 0;
    have  = 0;
    b     = 8'h00;
    if (en) begin
      if (m_wait) begin
        if (s) m_wait = 0;
      end else if (!m_busy) begin
        if (!s) begin
          m_busy = 1;
          mq.delete();
        end
      end else begin
        mq.push_back(s);
        if (mq.size() == 10) begin
          m_busy = 0;
          ones = 0;
          for (int i = 0; i < 8; i++) b[7-i] = mq[i];
          for (int i = 0; i < 9; i++) ones += int'(mq[i]);
          if (!mq[9]) begin
            m_frm  = 1;
            m_wait = 1;
          end else if (ones % 2 == 1) begin
            m_par = 1;
          end else begin
            have = 1;
          end
        end
      end
    end
    if (have) begin
      if (!m_valid || rdy) begin
        m_data  = b;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got={v,data,par,frm,ovr}=%03h want=%03h", name, got, want);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {rx_bus.VALID, rx_bus.DATA_OUT, rx_bus.PAR_ERR, rx_bus.FRM_ERR, rx_bus.OVERRUN};
  endfunction

  task automatic expect_out(input string name, input bit v, input logic [7:0] d,
                            input bit p, input bit f, input bit o);
    chk(name, dut_out(), {v, d, p, f, o});
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit rst, input bit en, input bit s, input bit rdy);
    RESET        = rst;
    ENABLE       = en;
    S_IN         = s;
    rx_bus.READY = rdy;
    @(posedge CLOCK);
    model_edge(rst, en, s, rdy);
    #1;
    chk("model", dut_out(), {m_valid, m_data, m_par, m_frm, m_ovr});
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input bit rdy_stop);
    step(0, 1, 0, 0);
    for (int i = 7; i >= 0; i--) step(0, 1, d[i], 0);
    step(0, 1, (^d) ^ bad_par, 0);
    step(0, 1, stop, rdy_stop);
  endtask

  typedef struct {
    logic [7:0] dat;
    bit         bad_par;
    bit         stop;
    bit         rdy_stop;
    bit         ack;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_par;
    bit         exp_frm;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] tmp;
    logic [7:0] rd;
    bit         en;
    total = 0;
    bad   = 0;

    vecs[0] = '{8'hA5, 0, 1, 0, 1, 8'hA5, 1, 0, 0, 0};
    vecs[1] = '{8'h01, 1, 1, 0, 0, 8'hA5, 0, 1, 0, 0};
    vecs[2] = '{8'h3C, 0, 1, 0, 1, 8'h3C, 1, 0, 0, 0};
    vecs[3] = '{8'h11, 0, 1, 0, 0, 8'h11, 1, 0, 0, 0};
    vecs[4] = '{8'h22, 0, 1, 0, 0, 8'h11, 1, 0, 0, 1};
    vecs[5] = '{8'h33, 0, 1, 1, 1, 8'h33, 1, 0, 0, 0};
    vecs[6] = '{8'h42, 0, 1, 0, 0, 8'h42, 1, 0, 0, 0};

    // Reset state.
    step(1, 1, 0, 1);
    step(1, 0, 1, 0);
    expect_out("reset", 0, 8'h00, 0, 0, 0);

    // Frame table; a disabled edge between rows samples nothing,
    // so consecutive rows are back-to-back on the line.
    foreach (vecs[i]) begin
      send_frame(vecs[i].dat, vecs[i].bad_par, vecs[i].stop, vecs[i].rdy_stop);
      expect_out($sformatf("row%0d_stop", i), vecs[i].exp_valid, vecs[i].exp_data,
                 vecs[i].exp_par, vecs[i].exp_frm, vecs[i].exp_ovr);
      step(0, 0, 1, vecs[i].ack);
      expect_out($sformatf("row%0d_after", i), vecs[i].exp_valid && !vecs[i].ack,
                 vecs[i].exp_data, 0, 0, 0);
    end

    // Framing error, line held low, then recovery.
    step(0, 0, 1, 1);
    expect_out("frm_pre", 0, 8'h42, 0, 0, 0);
    send_frame(8'hFF, 0, 0, 0);
    expect_out("frm_pulse", 0, 8'h42, 0, 1, 0);
    step(0, 0, 0, 0);
    expect_out("frm_width", 0, 8'h42, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      expect_out("frm_low", 0, 8'h42, 0, 0, 0);
    end
    step(0, 1, 1, 0);
    send_frame(8'h80, 0, 1, 0);
    expect_out("frm_recover", 1, 8'h80, 0, 0, 0);
    step(0, 0, 1, 1);
    expect_out("frm_ack", 0, 8'h80, 0, 0, 0);

    // 0xC3 with ENABLE 1,0,0 pattern; garbage on disabled edges.
    tmp = 8'hC3;
    step(0, 1, 0, 0);
    step(0, 0, $urandom_range(0, 1), 0);
    step(0, 0, $urandom_range(0, 1), 0);
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, tmp[i], 0);
      step(0, 0, $urandom_range(0, 1), 0);
      step(0, 0, $urandom_range(0, 1), 0);
    end
    step(0, 1, ^tmp, 0);
    step(0, 0, $urandom_range(0, 1), 0);
    step(0, 0, $urandom_range(0, 1), 0);
    step(0, 1, 1, 0);
    expect_out("toggle_en", 1, 8'hC3, 0, 0, 0);

    // Reset after the 4th data bit of 0x5A, byte 0xC3 still pending.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(1, 1, 0, 1);
    expect_out("mid_reset", 0, 8'h00, 0, 0, 0);
    step(0, 1, 1, 0);
    expect_out("mid_reset_quiet", 0, 8'h00, 0, 0, 0);
    send_frame(8'h5A, 0, 1, 0);
    expect_out("after_reset", 1, 8'h5A, 0, 0, 0);
    step(0, 0, 1, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [10:0] bits;
      bit bp, bs;
      if ($urandom_range(0, 99) < 2) step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step(0, $urandom_range(0, 1), 1, $urandom_range(0, 1));
      rd = 8'($urandom);
      bp = ($urandom_range(0, 99) < 15);
      bs = ($urandom_range(0, 99) >= 10);
      bits = {1'b0, rd, (^rd) ^ bp, bs};
      for (int i = 10; i >= 0; i--) begin
        do begin
          en = ($urandom_range(0, 3) != 0);
          step(0, en, en ? bits[i] : 1'($urandom_range(0, 1)), $urandom_range(0, 1));
        end while (!en);
      end
      if (!bs) begin
        repeat ($urandom_range(0, 4)) step(0, $urandom_range(0, 1), 0, $urandom_range(0, 1));
        step(0, 1, 1, $urandom_range(0, 1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
